sep_blur_engine: RTL and testbench

SEP_BLUR_ENGINE -- requirements
Module: sep_blur_engine

---
 rtl/sep_blur_engine.sv | 136 +++++++++++++
 tb/tb_sep_blur_engine.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sep_blur_engine.sv
// Separable 5-tap (1,4,6,4,1) blur: a horizontal pass over one input row into
// a 5-row history, then a vertical pass down the history to produce one strip.
module sep_blur_tap5 #(
    parameter int PIX_W = 8
) (
    input  logic [4:0][PIX_W-1:0] p_i,
    output logic [PIX_W-1:0]      y_o
);
    localparam int SW = PIX_W + 4;
    logic [SW-1:0] a, b, c, d, e, s;

    assign a = SW'(p_i[0]);
    assign b = SW'(p_i[1]);
    assign c = SW'(p_i[2]);
    assign d = SW'(p_i[3]);
    assign e = SW'(p_i[4]);
    // Weights sum to 16, so the rounded result always fits back into PIX_W.
    assign s = a + (b << 2) + (c << 2) + (c << 1) + (d << 2) + e + SW'(8);
    assign y_o = s[SW-1:4];
endmodule

module sep_blur_engine #(
    parameter int PIX_W = 8,
    parameter int STRIP = 16,
    parameter int LANES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(STRIP+4)*PIX_W-1:0] in_row,
    input  logic                       first_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [STRIP*PIX_W-1:0]     out_strip
);
    localparam int CW = $clog2(STRIP);
    localparam int RW = $clog2(STRIP + 4);
    localparam logic [CW-1:0] LAST_COL = CW'(STRIP - LANES);
    localparam logic [CW-1:0] STEP     = CW'(LANES);

    typedef enum logic [1:0] {IDLE, HPASS, VPASS, DONE} state_t;

    state_t                              state_q;
    logic [CW-1:0]                       col_q;
    logic [STRIP+3:0][PIX_W-1:0]         row_q;
    logic                                first_q;
    logic [4:0][STRIP-1:0][PIX_W-1:0]    hist_q;
    logic [STRIP-1:0][PIX_W-1:0]         out_q;
    logic                                out_valid_q;
    logic [LANES-1:0][PIX_W-1:0]         hres, vres;
    logic [LANES-1:0][CW-1:0]            lidx;

    assign in_ready  = (state_q == IDLE) && !clear;
    assign out_valid = out_valid_q;
    assign out_strip = out_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [4:0][PIX_W-1:0] htap, vtap;
        assign lidx[l] = col_q + CW'(l);
        always_comb begin
            htap = '0;
            vtap = '0;
            for (int t = 0; t < 5; t++) begin
                htap[t] = row_q[RW'(col_q) + RW'(l + t)];
                vtap[t] = hist_q[t][lidx[l]];
            end
        end
        sep_blur_tap5 #(.PIX_W(PIX_W)) u_htap (.p_i(htap), .y_o(hres[l]));
        sep_blur_tap5 #(.PIX_W(PIX_W)) u_vtap (.p_i(vtap), .y_o(vres[l]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            first_q     <= 1'b0;
            hist_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            first_q     <= 1'b0;
            hist_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    row_q       <= in_row;
                    first_q     <= first_row;
                    hist_q[4:1] <= hist_q[3:0];
                    col_q       <= '0;
                    state_q     <= HPASS;
                end
                HPASS: begin
                    // A first row stands in for the rows above it as well.
                    for (int l = 0; l < LANES; l++) begin
                        hist_q[0][lidx[l]] <= hres[l];
                        if (first_q)
                            for (int r = 1; r < 5; r++) hist_q[r][lidx[l]] <= hres[l];
                    end
                    if (col_q == LAST_COL) begin
                        col_q   <= '0;
                        state_q <= VPASS;
                    end else begin
                        col_q <= col_q + STEP;
                    end
                end
                VPASS: begin
                    for (int l = 0; l < LANES; l++) out_q[lidx[l]] <= vres[l];
                    if (col_q == LAST_COL) begin
                        col_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        col_q <= col_q + STEP;
                    end
                end
                DONE: begin
                    // One settling cycle in DONE before the strip is offered.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sep_blur_engine.sv
// Bench for sep_blur_engine: directed corner cases plus random rows checked
// against an arithmetic model of the two-pass blur with a 5-row history.
module tb_sep_blur_engine;
    localparam int P  = 8;
    localparam int S  = 16;
    localparam int L  = 2;
    localparam int IW = (S + 4) * P;
    localparam int OW = S * P;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          first_row = 1'b0;
    logic          out_ready = 1'b1;
    logic [IW-1:0] in_row = '0;
    logic          in_ready, out_valid;
    logic [OW-1:0] out_strip;

    int checks = 0;
    int failures = 0;
    int mh[5][S];

    always #5 clk = ~clk;

    sep_blur_engine #(.PIX_W(P), .STRIP(S), .LANES(L)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row), .first_row(first_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_strip(out_strip)
    );

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int k5(input int a, input int b, input int c, input int d, input int e);
        return (a + 4 * b + 6 * c + 4 * d + e + 8) / 16;
    endfunction

    function automatic logic [IW-1:0] const_row(input int v);
        logic [IW-1:0] r;
        for (int k = 0; k < S + 4; k++) r[k*P +: P] = P'(v);
        return r;
    endfunction

    function automatic logic [OW-1:0] const_strip(input int v);
        logic [OW-1:0] r;
        for (int j = 0; j < S; j++) r[j*P +: P] = P'(v);
        return r;
    endfunction

    function automatic logic [IW-1:0] rand_row();
        logic [IW-1:0] r;
        for (int k = 0; k < S + 4; k++) r[k*P +: P] = P'($urandom_range(0, 255));
        return r;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 5; r++)
            for (int j = 0; j < S; j++) mh[r][j] = 0;
    endtask

    task automatic model_accept(input logic [IW-1:0] row, input bit first, output logic [OW-1:0] exp);
        int px[S+4];
        int h[S];
        for (int k = 0; k < S + 4; k++) px[k] = int'(row[k*P +: P]);
        for (int j = 0; j < S; j++) h[j] = k5(px[j], px[j+1], px[j+2], px[j+3], px[j+4]);
        if (first) begin
            for (int r = 0; r < 5; r++)
                for (int j = 0; j < S; j++) mh[r][j] = h[j];
        end else begin
            for (int r = 4; r > 0; r--)
                for (int j = 0; j < S; j++) mh[r][j] = mh[r-1][j];
            for (int j = 0; j < S; j++) mh[0][j] = h[j];
        end
        for (int j = 0; j < S; j++)
            exp[j*P +: P] = P'(k5(mh[0][j], mh[1][j], mh[2][j], mh[3][j], mh[4][j]));
    endtask

    task automatic accept(input logic [IW-1:0] row, input bit first);
        @(negedge clk);
        in_row = row;
        first_row = first;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
            $fatal(1, "accept timeout");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
        checks++; if (out_strip !== '0) begin failures++; $display("FAIL reset_out_strip got=%h required=0", out_strip); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
        model_clear();
    endtask

    task automatic test_const100();
        logic [OW-1:0] exp;
        int lat;
        model_accept(const_row(100), 1'b1, exp);
        accept(const_row(100), 1'b1);
        wait_valid(lat);
        checks++; if (lat !== 17) begin failures++; $display("FAIL c100_latency got=%0d required=17", lat); end
        checks++; if (out_strip !== const_strip(100)) begin failures++; $display("FAIL c100_strip got=%h required=%h", out_strip, const_strip(100)); end
        checks++; if (out_strip !== exp) begin failures++; $display("FAIL c100_model got=%h required=%h", out_strip, exp); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL c100_ready_in_handshake got=%0b required=0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL c100_after_handshake in_ready=%0b out_valid=%0b required 1,0", in_ready, out_valid); end
    endtask

    task automatic test_impulse();
        logic [IW-1:0] row;
        logic [OW-1:0] exp, lit;
        int imp[5] = '{1, 4, 6, 4, 1};
        int lat;
        lit = '0;
        for (int j = 0; j < 5; j++) lit[j*P +: P] = P'(imp[j]);
        row = '0;
        row[4*P +: P] = 8'd16;
        model_accept(row, 1'b1, exp);
        accept(row, 1'b1);
        wait_valid(lat);
        checks++; if (out_strip !== lit) begin failures++; $display("FAIL impulse_first got=%h required=%h", out_strip, lit); end
        checks++; if (out_strip !== exp) begin failures++; $display("FAIL impulse_first_model got=%h required=%h", out_strip, exp); end
        @(negedge clk);
        row = '0;
        model_accept(row, 1'b0, exp);
        accept(row, 1'b0);
        wait_valid(lat);
        checks++; if (out_strip !== lit) begin failures++; $display("FAIL impulse_follow got=%h required=%h", out_strip, lit); end
        checks++; if (lat !== 17) begin failures++; $display("FAIL impulse_follow_latency got=%0d required=17", lat); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [IW-1:0] row;
        logic [OW-1:0] exp, snap;
        int lat;
        row = rand_row();
        model_accept(row, 1'b0, exp);
        out_ready = 1'b0;
        accept(row, 1'b0);
        wait_valid(lat);
        snap = out_strip;
        checks++; if (snap !== exp) begin failures++; $display("FAIL bp_strip got=%h required=%h", snap, exp); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_strip !== snap || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d out_valid=%0b in_ready=%0b strip=%h required 1,0,%h", i, out_valid, in_ready, out_strip, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release out_valid=%0b in_ready=%0b required 0,1", out_valid, in_ready); end
    endtask

    task automatic test_rst_mid();
        logic [OW-1:0] exp;
        bit seen;
        int lat;
        accept(rand_row(), 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        model_clear();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_ready in_ready=%0b out_valid=%0b required 1,0", in_ready, out_valid); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL rst_mid_spurious_valid got=1 required=0"); end
        model_accept(const_row(50), 1'b1, exp);
        accept(const_row(50), 1'b1);
        wait_valid(lat);
        checks++; if (out_strip !== const_strip(50) || lat !== 17) begin failures++; $display("FAIL rst_mid_c50 strip=%h lat=%0d required=%h,17", out_strip, lat, const_strip(50)); end
        checks++; if (out_strip !== exp) begin failures++; $display("FAIL rst_mid_model got=%h required=%h", out_strip, exp); end
        @(negedge clk);
    endtask

    task automatic test_clear();
        logic [OW-1:0] exp;
        bit seen;
        int lat;
        @(negedge clk);
        clear = 1'b1;
        in_valid = 1'b1;
        in_row = const_row(200);
        first_row = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL clear_in_ready got=%0b required=0", in_ready); end
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        model_clear();
        seen = 1'b0;
        repeat (25) begin @(negedge clk); if (out_valid || !in_ready) seen = 1'b1; end
        checks++; if (seen) begin failures++; $display("FAIL clear_row_taken got=1 required=0"); end
        model_accept(const_row(160), 1'b0, exp);
        accept(const_row(160), 1'b0);
        wait_valid(lat);
        checks++; if (out_strip !== const_strip(10)) begin failures++; $display("FAIL clear_c160 got=%h required=%h", out_strip, const_strip(10)); end
        checks++; if (out_strip !== exp) begin failures++; $display("FAIL clear_model got=%h required=%h", out_strip, exp); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [IW-1:0] row;
        logic [OW-1:0] exp;
        bit first;
        int lat, d;
        for (int n = 0; n < 12; n++) begin
            row = rand_row();
            first = ($urandom_range(0, 3) == 0);
            d = $urandom_range(0, 3);
            out_ready = (d == 0);
            model_accept(row, first, exp);
            accept(row, first);
            wait_valid(lat);
            checks++; if (lat !== 17) begin failures++; $display("FAIL rand_latency n=%0d got=%0d required=17", n, lat); end
            checks++; if (out_strip !== exp) begin failures++; $display("FAIL rand_strip n=%0d got=%h required=%h", n, out_strip, exp); end
            if (d > 0) repeat (d) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_const100();
        test_impulse();
        test_backpressure();
        test_rst_mid();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
